// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
// Holds the FSM state encoding, the legal oversampling ratios, the default
// ratio used after reset or for an illegal request, and a legality helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int PRESC_8       = 8;
  localparam int PRESC_16      = 16;
  localparam int PRESC_32      = 32;
  localparam int PRESC_DEFAULT = PRESC_8;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversample (edge) and bit counter pair for the UART receiver.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   enable     - advance counters this cycle
//   clear      - force both counters to zero (wins over enable)
//   prescale   - oversampling ratio of the current frame
//   edge_cnt   - position inside the current bit, wraps prescale-1 -> 0
//   bit_cnt    - bit index inside the frame, steps on every edge wrap
//   last_edge  - combinational flag: edge_cnt is at prescale-1
module uart_edge_bit_counter #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] prescale,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               last_edge
);

  assign last_edge = (edge_cnt == prescale - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (last_edge) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames the serial line into start, data, optional
// parity and stop bits, and steers the sampler, deserializer and parity
// checker.
// Ports:
//   clk, rst        - oversampling clock, asynchronous active-low reset
//   rx_in           - synchronized serial line, idle high
//   prescale        - oversampling ratio (8/16/32, anything else acts as 8)
//   par_en          - frame carries a parity bit
//   sampled_bit     - voted bit from the sampler, valid at edge_cnt==prescale-1
//   par_err         - registered error flag from the parity checker
//   edge_cnt        - oversample position inside the current bit
//   bit_cnt         - bit index: 0 start, 1..DATA_WIDTH data, parity, stop
//   dat_samp_en     - sampler enable, high outside IDLE
//   deser_en        - one-cycle strobe at the end of each data bit
//   par_chk_en      - one-cycle strobe at the end of the parity bit
//   data_valid      - one-cycle pulse: frame received with no error
//   framing_err     - one-cycle pulse: stop bit sampled low
//   parity_err      - one-cycle pulse: parity checker flagged the frame
//   fsm_state       - current controller state, for observation
// Result pulses have no backpressure: a consumer must take data_valid in the
// single cycle it is high; there is no ready input.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               sampled_bit,
  input  logic               par_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               par_chk_en,
  output logic               data_valid,
  output logic               framing_err,
  output logic               parity_err,
  output rx_state_e          fsm_state
);

  rx_state_e          state;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q;
  logic [PRESC_W-1:0] presc_in;
  logic               last_edge;
  logic               cnt_clear;
  logic               cnt_enable;
  logic               frame_par_err;

  assign presc_in = prescale_legal(32'(prescale)) ? prescale : PRESC_W'(PRESC_DEFAULT);

  // Counters sit at zero in IDLE and are zeroed on the cycle that leaves a
  // frame (glitch abort or stop bit done), so IDLE->START always begins at 0.
  assign cnt_enable = (state != ST_IDLE);
  assign cnt_clear  = (state == ST_IDLE)
                   || (state == ST_START && last_edge && sampled_bit)
                   || (state == ST_STOP  && last_edge);

  uart_edge_bit_counter #(
    .PRESC_W (PRESC_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .enable    (cnt_enable),
    .clear     (cnt_clear),
    .prescale  (presc_q),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .last_edge (last_edge)
  );

  // Strobes are decoded from registered state and count so they line up with
  // the cycle in which sampled_bit is valid.
  assign dat_samp_en = (state != ST_IDLE);
  assign deser_en    = (state == ST_DATA)   && last_edge;
  assign par_chk_en  = (state == ST_PARITY) && last_edge;
  assign fsm_state   = state;

  assign frame_par_err = par_en_q && par_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      presc_q     <= PRESC_W'(PRESC_DEFAULT);
      par_en_q    <= 1'b0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_in) begin
            state    <= ST_START;
            presc_q  <= presc_in;
            par_en_q <= par_en;
          end
        end
        ST_START: begin
          if (last_edge) state <= sampled_bit ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (last_edge && bit_cnt == 4'(DATA_WIDTH))
            state <= par_en_q ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (last_edge) state <= ST_STOP;
        end
        ST_STOP: begin
          if (last_edge) begin
            state       <= ST_IDLE;
            framing_err <= !sampled_bit;
            parity_err  <= frame_par_err;
            data_valid  <= sampled_bit && !frame_par_err;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl. Frames are driven bit by bit; a frame-level model
// derives from the protocol timing the cycle of every strobe and result pulse
// and queues them; a negedge monitor pops and compares each observed event.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam logic [3:0] EV_DV = 4'd1, EV_FE = 4'd2, EV_PE = 4'd3, EV_DS = 4'd4, EV_PC = 4'd5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = 6'd8;
  logic          par_en = 1'b0;
  logic          sampled_bit = 1'b1;
  logic          par_err = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en, deser_en, par_chk_en;
  logic          data_valid, framing_err, parity_err;
  rx_state_e     fsm_state;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .sampled_bit (sampled_bit),
    .par_err     (par_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .fsm_state   (fsm_state)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ev(input logic [3:0] kind, input int c);
    return {kind, 28'(c)};
  endfunction

  task automatic observe(input logic [3:0] kind);
    logic [31:0] got;
    got = ev(kind, cyc);
    if (exp_q.size() == 0) check("unexpected_event", got, 32'h0);
    else check("event", got, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (data_valid)  observe(EV_DV);
      if (framing_err) observe(EV_FE);
      if (parity_err)  observe(EV_PE);
      if (deser_en)    observe(EV_DS);
      if (par_chk_en)  observe(EV_PC);
    end
  end

  function automatic logic [15:0] all_outs();
    return {data_valid, framing_err, parity_err, deser_en, par_chk_en, dat_samp_en, bit_cnt, edge_cnt};
  endfunction

  function automatic int eff_presc(input int p);
    return (p == 8 || p == 16 || p == 32) ? p : 8;
  endfunction

  // Frame-level reference: low seen in cycle t; bit k occupies cycles
  // t+1+p*k .. t+p*(k+1); strobes land on the last cycle of their bit and the
  // result pulse comes one cycle after the stop bit ends.
  task automatic model_frame(input int t, input int p_in, input logic pe,
                             input logic stop_bit, input logic perr);
    int p, n, r;
    p = eff_presc(p_in);
    n = 2 + DW + int'(pe);
    for (int k = 1; k <= DW; k++) exp_q.push_back(ev(EV_DS, t + p * (k + 1)));
    if (pe) exp_q.push_back(ev(EV_PC, t + p * (DW + 2)));
    r = t + 1 + p * n;
    if (stop_bit && !(pe && perr)) exp_q.push_back(ev(EV_DV, r));
    if (!stop_bit)                  exp_q.push_back(ev(EV_FE, r));
    if (pe && perr)                 exp_q.push_back(ev(EV_PE, r));
  endtask

  // driver tasks (called and returning at posedge+1)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int k);
    rx_in = 1'b1;
    for (int i = 0; i < k; i++) begin
      sampled_bit = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic drive_frame(input int p_in, input logic pe, input logic [DW-1:0] data,
                             input logic stop_bit, input logic perr, input bit scramble,
                             input bit early_low, input int abort_bit);
    int p, n;
    logic b;
    p = eff_presc(p_in);
    n = 2 + DW + int'(pe);
    prescale = PW'(p_in);
    par_en = pe;
    rx_in = 1'b0;
    sampled_bit = 1'($urandom_range(0, 1));
    model_frame(cyc, p_in, pe, stop_bit, perr);
    step();
    for (int k = 0; k < n; k++) begin
      if (k == 0)           b = 1'b0;
      else if (k <= DW)     b = data[k-1];
      else if (k == n - 1)  b = stop_bit;
      else                  b = ^data;
      for (int j = 0; j < p; j++) begin
        rx_in = b;
        sampled_bit = b;
        par_err = (k == n - 1) ? perr : 1'($urandom_range(0, 1));
        if (early_low && k == n - 1 && j == p - 1) rx_in = 1'b0;
        if (scramble) begin
          prescale = PW'($urandom_range(0, 40));
          par_en = 1'($urandom_range(0, 1));
        end
        if (abort_bit == k && j == p / 2) return;
        step();
      end
    end
    rx_in = 1'b1;
    sampled_bit = 1'b1;
    par_err = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    // reset state
    #1 rst = 1'b0;
    #1;
    check("reset_outs", 32'(all_outs()), 32'h0);
    check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
    step(); step();
    rst = 1'b1;
    mon_en = 1'b1;
    idle_cycles(3);
    check("idle_outs", 32'(all_outs()), 32'h0);

    // 0xA5, prescale 8, no parity
    drive_frame(8, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles(3);
    check("drain_a5", 32'(exp_q.size()), 32'h0);

    // 0x3C, prescale 16, parity clean
    drive_frame(16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles(3);
    check("drain_3c", 32'(exp_q.size()), 32'h0);

    // start-bit glitch: low two cycles, sampler votes high
    prescale = 6'd8;
    par_en = 1'b0;
    t = cyc;
    rx_in = 1'b0;
    sampled_bit = 1'b1;
    step();
    step();
    rx_in = 1'b1;
    while (cyc < t + 8) step();
    check("glitch_start", 32'(fsm_state), 32'(ST_START));
    step();
    check("glitch_idle", 32'(fsm_state), 32'(ST_IDLE));
    check("glitch_cnt", {16'h0, all_outs()}, 32'h0);
    idle_cycles(2);

    // framing error
    drive_frame(8, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles(2);

    // parity error, then back-to-back clean frame
    drive_frame(8, 1'b1, 8'h96, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    drive_frame(8, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles(3);
    check("drain_b2b", 32'(exp_q.size()), 32'h0);

    // line low in the final stop cycle must not start a frame
    drive_frame(16, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    check("early_low_idle", 32'(fsm_state), 32'(ST_IDLE));
    idle_cycles(2);
    check("early_low_still_idle", 32'(fsm_state), 32'(ST_IDLE));

    // randomized frames, mid-frame config changes, illegal prescale values
    for (int i = 0; i < 12; i++) begin
      int sel;
      int pi;
      sel = $urandom_range(0, 4);
      pi = (sel == 0) ? 8 : (sel == 1) ? 16 : (sel == 2) ? 32 : (sel == 3) ? 8 : $urandom_range(0, 40);
      drive_frame(pi, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 1)), 1'b1, 1'b0, -1);
      idle_cycles($urandom_range(0, 3));
    end
    idle_cycles(3);
    check("drain_random", 32'(exp_q.size()), 32'h0);

    // asynchronous reset in the middle of bit 4
    drive_frame(8, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    check("abort_bit_cnt", 32'(bit_cnt), 32'd4);
    check("abort_edge_cnt", 32'(edge_cnt), 32'd4);
    #1 rst = 1'b0;
    #1;
    check("async_reset_outs", 32'(all_outs()), 32'h0);
    check("async_reset_state", 32'(fsm_state), 32'(ST_IDLE));
    exp_q.delete();
    rx_in = 1'b1;
    step(); step();
    rst = 1'b1;
    idle_cycles(2);
    drive_frame(32, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles(3);
    check("drain_post_reset", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
